// File: rtl/instr_mem_sync_if.sv
// Fetch/load bus between the CPU fetch stage (master) and the instruction memory (slave).
// req and rsp are valid/ready: a beat transfers on a rising edge where valid && ready; valid-side payload holds stable until then.
interface instr_mem_sync_if;
    logic        init_done;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_err;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        input  init_done, load_err, req_ready, rsp_valid, rsp_data, rsp_err,
        output load_en, load_addr, load_data, req_valid, req_addr, rsp_ready
    );

    modport slave (
        output init_done, load_err, req_ready, rsp_valid, rsp_data, rsp_err,
        input  load_en, load_addr, load_data, req_valid, req_addr, rsp_ready
    );
endinterface

// File: rtl/instr_mem_sync.sv
// Writable synchronous-read instruction memory: NOP fill after reset, program-load port,
// and a 1-deep registered valid/ready fetch port with error responses for bad addresses.
module instr_mem_sync #(
    parameter logic [31:0] BASE_ADDR = 32'h00400000,
    parameter int          DEPTH     = 256,
    parameter logic [31:0] FILL_WORD = 32'h00000033,
    parameter logic [31:0] ERR_WORD  = 32'hDEADBEEF
) (
    input  logic               clk,
    input  logic               rst,
    instr_mem_sync_if.slave    bus,
    output logic               dbg_state
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    state_t          state;
    logic [AW-1:0]   fill_cnt;
    logic [31:0]     mem [DEPTH];

    logic [31:0]     req_off;
    logic [31:0]     load_off;
    logic            req_ok;
    logic            load_ok;
    logic [AW-1:0]   req_idx;
    logic [AW-1:0]   load_idx;
    logic            accept;

    // Addresses below BASE_ADDR wrap to huge offsets and fail the span check.
    assign req_off  = bus.req_addr - BASE_ADDR;
    assign load_off = bus.load_addr - BASE_ADDR;
    assign req_ok   = (bus.req_addr[1:0] == 2'b00) && (req_off < SPAN);
    assign load_ok  = (bus.load_addr[1:0] == 2'b00) && (load_off < SPAN);
    assign req_idx  = req_off[AW+1:2];
    assign load_idx = load_off[AW+1:2];

    assign bus.req_ready = (state == RUN) && (!bus.rsp_valid || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;
    assign dbg_state     = state;

    // Single write port shared by the fill sequencer and the program loader.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[fill_cnt] <= FILL_WORD;
            end else if (bus.load_en && load_ok) begin
                mem[load_idx] <= bus.load_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= INIT;
            fill_cnt      <= '0;
            bus.init_done <= 1'b0;
            bus.load_err  <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.load_err <= 1'b0;
            case (state)
                INIT: begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == AW'(DEPTH - 1)) begin
                        state         <= RUN;
                        bus.init_done <= 1'b1;
                    end
                end
                RUN: begin
                    bus.load_err <= bus.load_en && !load_ok;
                    // Reads the pre-edge array content, so a same-cycle load is not seen.
                    if (accept) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= req_ok ? mem[req_idx] : ERR_WORD;
                        bus.rsp_err   <= !req_ok;
                    end else if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync: inputs driven and outputs sampled on the falling edge;
// fetch expectations come from a bench-side word model pushed into exp_q at acceptance.
module tb_instr_mem_sync;
    localparam logic [31:0] BASE = 32'h00400000;
    localparam logic [31:0] NOP  = 32'h00000033;
    localparam logic [31:0] ERRW = 32'hDEADBEEF;

    logic clk;
    logic rst;
    logic dbg_state;

    instr_mem_sync_if bus ();

    instr_mem_sync dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [32:0] exp_q[$];
    logic [32:0] got_q[$];
    int          got_cyc_q[$];
    logic [31:0] model [256];
    int          cyc;
    int          checks;
    int          passed;

    function automatic logic addr_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] == 2'b00) && (off < 32'd1024);
    endfunction

    function automatic logic [32:0] expect_rsp(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (addr_ok(a)) return {1'b0, model[off[9:2]]};
        return {1'b1, ERRW};
    endfunction

    // ---------------- driver tasks ----------------
    // One cycle from a falling edge to the next: drive, observe handshakes, update model.
    task automatic step(input logic le, input logic [31:0] la, input logic [31:0] ld,
                        input logic rv, input logic [31:0] ra, input logic rr);
        logic [31:0] off;
        bus.load_en   = le;
        bus.load_addr = la;
        bus.load_data = ld;
        bus.req_valid = rv;
        bus.req_addr  = ra;
        bus.rsp_ready = rr;
        #1;
        if (bus.req_valid && bus.req_ready) exp_q.push_back(expect_rsp(ra));
        if (bus.rsp_valid && bus.rsp_ready) begin
            got_q.push_back({bus.rsp_err, bus.rsp_data});
            got_cyc_q.push_back(cyc);
        end
        if (le && bus.init_done && addr_ok(la)) begin
            off = la - BASE;
            model[off[9:2]] = ld;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic fill_model();
        for (int i = 0; i < 256; i++) model[i] = NOP;
    endtask

    task automatic flush_sb();
        exp_q.delete();
        got_q.delete();
        got_cyc_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        int bad;
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.init_done, bus.load_err, bus.req_ready, bus.rsp_valid, bus.rsp_err, dbg_state} !== 6'b0) begin
            $display("FAIL reset_flags: got id=%b le=%b rr=%b rv=%b re=%b st=%b, want all 0",
                     bus.init_done, bus.load_err, bus.req_ready, bus.rsp_valid, bus.rsp_err, dbg_state);
        end else passed++;
        checks++;
        if (bus.rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h want 00000000", bus.rsp_data);
        else passed++;

        fill_model();
        rst = 1'b0;
        n = 0; bad = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (bus.init_done === 1'b1) begin n = i; break; end
            if (bus.req_ready !== 1'b0 || bus.load_err !== 1'b0) bad++;
            // A load late in the fill, after word 8 is filled, must still be ignored.
            bus.load_en   = (i >= 250 && i <= 252);
            bus.load_addr = BASE + 32'h20;
            bus.load_data = 32'h12345678;
        end
        bus.load_en = 1'b0;
        checks++;
        if (n != 256) $display("FAIL init_latency: got %0d cycles want 256", n);
        else passed++;
        checks++;
        if (bad != 0) $display("FAIL init_quiet: got %0d cycles with req_ready/load_err high want 0", bad);
        else passed++;
        checks++;
        if (dbg_state !== 1'b1) $display("FAIL run_state: got %b want 1", dbg_state);
        else passed++;

        cyc = 0;
        flush_sb();
        step(1'b0, 0, 0, 1'b1, BASE + 32'h10, 1'b1);
        step(1'b0, 0, 0, 1'b1, BASE + 32'h20, 1'b1);
        idle(3);
        checks++;
        if (got_q.size() != 2 || exp_q.size() != 2) $display("FAIL reset_fetch_count: got %0d/%0d want 2", got_q.size(), exp_q.size());
        else passed++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [32:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e || g !== {1'b0, NOP}) $display("FAIL reset_fetch: got %h want %h", g, {1'b0, NOP});
            else passed++;
        end
        flush_sb();
    endtask

    task automatic test_load_fetch();
        step(1'b1, BASE + 32'h00, 32'h3e802403, 1'b0, 0, 1'b1);
        step(1'b1, BASE + 32'h04, 32'h3ec02483, 1'b0, 0, 1'b1);
        step(1'b1, BASE + 32'h18, 32'h00940533, 1'b0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1, BASE + 32'h00, 1'b1);
        step(1'b0, 0, 0, 1'b1, BASE + 32'h04, 1'b1);
        step(1'b0, 0, 0, 1'b1, BASE + 32'h18, 1'b1);
        idle(3);
        checks++;
        if (got_q.size() != 3) $display("FAIL b2b_count: got %0d want 3", got_q.size());
        else passed++;
        if (got_q.size() == 3) begin
            checks++;
            if (got_q[0] !== {1'b0, 32'h3e802403} || got_q[1] !== {1'b0, 32'h3ec02483} || got_q[2] !== {1'b0, 32'h00940533})
                $display("FAIL b2b_data: got %h %h %h want 03e802403 03ec02483 000940533", got_q[0], got_q[1], got_q[2]);
            else passed++;
            checks++;
            if (got_cyc_q[1] != got_cyc_q[0] + 1 || got_cyc_q[2] != got_cyc_q[1] + 1)
                $display("FAIL b2b_spacing: got cycles %0d %0d %0d want consecutive", got_cyc_q[0], got_cyc_q[1], got_cyc_q[2]);
            else passed++;
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [32:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) $display("FAIL b2b_sb: got %h want %h", g, e);
            else passed++;
        end
        flush_sb();
    endtask

    task automatic test_errors();
        step(1'b0, 0, 0, 1'b1, 32'h00400002, 1'b1);
        step(1'b0, 0, 0, 1'b1, 32'h00400400, 1'b1);
        step(1'b0, 0, 0, 1'b1, 32'h003FFFFC, 1'b1);
        idle(3);
        checks++;
        if (got_q.size() != 3) $display("FAIL err_count: got %0d want 3", got_q.size());
        else passed++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [32:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e || g !== {1'b1, ERRW}) $display("FAIL err_fetch: got %h want %h", g, {1'b1, ERRW});
            else passed++;
        end
        flush_sb();

        step(1'b1, 32'h00400401, 32'hCAFEF00D, 1'b0, 0, 1'b1);
        checks++;
        if (bus.load_err !== 1'b1) $display("FAIL load_err_pulse: got %b want 1", bus.load_err);
        else passed++;
        idle(1);
        checks++;
        if (bus.load_err !== 1'b0) $display("FAIL load_err_clear: got %b want 0", bus.load_err);
        else passed++;
        step(1'b0, 0, 0, 1'b1, BASE + 32'h00, 1'b1);
        step(1'b0, 0, 0, 1'b1, BASE + 32'h3FC, 1'b1);
        idle(3);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [32:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) $display("FAIL load_err_nowrite: got %h want %h", g, e);
            else passed++;
        end
        flush_sb();
    endtask

    task automatic test_backpressure();
        int bad;
        step(1'b0, 0, 0, 1'b1, BASE + 32'h00, 1'b0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h3e802403 || bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b0) bad++;
            // A request offered while stalled must not be taken.
            step(1'b0, 0, 0, 1'b1, BASE + 32'h18, 1'b0);
        end
        checks++;
        if (bad != 0) $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
        else passed++;
        step(1'b0, 0, 0, 1'b1, BASE + 32'h04, 1'b1);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h3ec02483)
            $display("FAIL release_next: got v=%b d=%h want v=1 d=3ec02483", bus.rsp_valid, bus.rsp_data);
        else passed++;
        idle(3);
        checks++;
        if (got_q.size() != 2) $display("FAIL bp_count: got %0d want 2", got_q.size());
        else passed++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [32:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) $display("FAIL bp_sb: got %h want %h", g, e);
            else passed++;
        end
        flush_sb();
    endtask

    task automatic test_collision();
        step(1'b1, BASE + 32'h1c, 32'h409405B3, 1'b0, 0, 1'b1);
        step(1'b1, BASE + 32'h1c, 32'h00947633, 1'b1, BASE + 32'h1c, 1'b1);
        step(1'b0, 0, 0, 1'b1, BASE + 32'h1c, 1'b1);
        idle(3);
        checks++;
        if (got_q.size() != 2) $display("FAIL coll_count: got %0d want 2", got_q.size());
        else passed++;
        if (got_q.size() == 2) begin
            checks++;
            if (got_q[0] !== {1'b0, 32'h409405B3} || got_q[1] !== {1'b0, 32'h00947633})
                $display("FAIL collision: got %h %h want 0409405b3 000947633", got_q[0], got_q[1]);
            else passed++;
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [32:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) $display("FAIL coll_sb: got %h want %h", g, e);
            else passed++;
        end
        flush_sb();
    endtask

    task automatic test_random();
        logic [31:0] ra;
        logic [31:0] la;
        for (int i = 0; i < 200; i++) begin
            ra = BASE + 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) ra = ra + ($urandom_range(0, 1) ? 32'h1 : 32'h400);
            la = BASE + 32'($urandom_range(0, 15) * 4);
            step($urandom_range(0, 3) == 0, la, $urandom, 1'($urandom_range(0, 1)), ra, $urandom_range(0, 3) != 0);
        end
        idle(4);
        checks++;
        if (got_q.size() != exp_q.size() || got_q.size() == 0)
            $display("FAIL rand_count: got %0d responses want %0d (nonzero)", got_q.size(), exp_q.size());
        else passed++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [32:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) $display("FAIL rand_sb: got %h want %h", g, e);
            else passed++;
        end
        flush_sb();
    endtask

    task automatic test_reset_mid();
        int n;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (bus.init_done === 1'b1) begin n = i; break; end
        end
        checks++;
        if (n != 256) $display("FAIL midfill_restart: got %0d cycles want 256", n);
        else passed++;

        step(1'b1, BASE + 32'h08, 32'h11112222, 1'b0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1, BASE + 32'h00, 1'b0);
        checks++;
        if (bus.rsp_valid !== 1'b1) $display("FAIL pre_rst_valid: got %b want 1", bus.rsp_valid);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0)
            $display("FAIL rst_clears_rsp: got v=%b rr=%b want 0 0", bus.rsp_valid, bus.req_ready);
        else passed++;
        flush_sb();
        fill_model();
        rst = 1'b0;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (bus.init_done === 1'b1) begin n = i; break; end
        end
        checks++;
        if (n != 256) $display("FAIL rst_run_latency: got %0d cycles want 256", n);
        else passed++;
        step(1'b0, 0, 0, 1'b1, BASE + 32'h00, 1'b1);
        step(1'b0, 0, 0, 1'b1, BASE + 32'h04, 1'b1);
        step(1'b0, 0, 0, 1'b1, BASE + 32'h08, 1'b1);
        step(1'b0, 0, 0, 1'b1, BASE + 32'h1c, 1'b1);
        idle(3);
        checks++;
        if (got_q.size() != 4) $display("FAIL refill_count: got %0d want 4", got_q.size());
        else passed++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [32:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e || g !== {1'b0, NOP}) $display("FAIL refill_nop: got %h want %h", g, {1'b0, NOP});
            else passed++;
        end
        flush_sb();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        passed = 0;
        cyc    = 0;
        rst    = 1'b1;
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b1;
        test_reset();
        test_load_fetch();
        test_errors();
        test_backpressure();
        test_collision();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
- Parametrised, synchronous-read instruction memory for the pipelined CPU fetch stage.
- Replaces the fixed-content combinational program ROM with a writable word array:
  - a program-load port writes words into the array;
  - a valid/ready fetch port returns one word per request after 1 cycle, with a 1-entry output register and backpressure.
- After reset, an init sequencer fills the array with NOPs before fetches are accepted.
- Misaligned or out-of-range accesses return an error word with an error flag.

Parameters:
- BASE_ADDR, 32'h00400000, byte address of word 0.
- DEPTH, 256, number of 32-bit words; power of two, at least 4.
- FILL_WORD, 32'h00000033, value written to every word during init (add x0,x0,x0 NOP).
- ERR_WORD, 32'hDEADBEEF, data returned on an erroneous fetch.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- init_done  out  1  high once array fill is complete.
- load_en  in  1  program-load write strobe.
- load_addr  in  32  byte address of the word to write.
- load_data  in  32  instruction word to write.
- load_err  out  1  1-cycle pulse: the previous-cycle load was rejected.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request accepted when high with req_valid.
- req_addr  in  32  fetch byte address (PC).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  32  fetched instruction word.
- rsp_err  out  1  response is an error; rsp_data = ERR_WORD.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - init_done=0, load_err=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - FSM enters INIT with fill counter = 0.
- INIT state:
  - Each cycle writes FILL_WORD to word[counter], then increments the counter.
  - After writing word DEPTH-1, moves to RUN. Fill takes exactly DEPTH cycles.
  - In INIT: req_ready=0 and load_en is ignored (no write, no load_err).
- RUN state:
  - init_done=1.
  - Stays in RUN until rst is asserted. rst in any state, including mid-fill, restarts INIT from word 0.
- Address decode (same rule for fetch and load):
  - offset = addr - BASE_ADDR, computed modulo 2^32.
  - Valid iff addr[1:0]==0 and offset < 4*DEPTH.
  - Word index = offset[log2(DEPTH)+1:2].
  - Addresses below BASE_ADDR wrap to large offsets and are therefore invalid.
- Load:
  - In RUN with load_en=1 and a valid address, word[index] <= load_data at the clock edge.
  - With an invalid address there is no write, and load_err=1 in the next cycle only.
- Fetch handshake:
  - req_ready = RUN and (rsp_valid==0 or rsp_ready==1).
  - A request is accepted on a cycle with req_valid and req_ready.
  - On the next edge after acceptance: rsp_valid=1, rsp_data=word[index] or ERR_WORD, rsp_err = invalid address.
  - Latency: accept at edge N, response visible after edge N, consumable at edge N+1.
  - Holding response: when rsp_valid=1 and rsp_ready=0, rsp_data, rsp_err and rsp_valid stay stable and req_ready=0.
  - Back-to-back: with rsp_ready held at 1, one request is accepted every cycle; throughput is 1 word/cycle.
  - rsp_valid clears when rsp_ready=1 and no new request is accepted in the same cycle.
- Simultaneous load and fetch to the same word in the same cycle: the fetch returns the old content (read-before-write). The new word is visible to fetches accepted on the next cycle or later.
- rsp_data keeps its last value when rsp_valid=0. Consumers must ignore rsp_data unless rsp_valid=1.

Test Plan:
- Reset then poll:
  - rst high 2 cycles, then low.
  - init_done rises exactly 256 cycles after rst falls; req_ready=0 throughout INIT.
  - A fetch of 0x00400010 then returns 0x00000033 with rsp_err=0.
- Load/fetch program, rsp_ready=1:
  - Load 0x00400000=0x3e802403, 0x00400004=0x3ec02483, 0x00400018=0x00940533.
  - Fetch all three back-to-back: responses in order on consecutive cycles, rsp_err=0, correct data.
- Error cases:
  - Fetch 0x00400002 (misaligned), 0x00400400 (one past end) and 0x003FFFFC (below base).
  - Each returns rsp_data=0xDEADBEEF with rsp_err=1.
  - Load to 0x00400401: load_err pulses for 1 cycle and no array word changes.
- Backpressure:
  - Hold rsp_ready=0 after fetching 0x00400000.
  - rsp_data stays 0x3e802403 and req_ready=0 for 5 cycles.
  - Raise rsp_ready with req_valid=1 at 0x00400004: the next response is 0x3ec02483 one cycle later.
- Same-word collision:
  - Word 0x0040001c holds 0x409405B3.
  - In the same cycle, load 0x00947633 to it and fetch it: response is 0x409405B3.
  - The following fetch of the same address returns 0x00947633.
- Reset mid-operation:
  - Assert rst at fill counter 100: INIT restarts from word 0 and init_done rises 256 cycles after rst falls.
  - Assert rst with rsp_valid=1: rsp_valid=0 and req_ready=0 after that edge; previously loaded words read back as 0x00000033.
